// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
package rv_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam int PC_W    = 64;

   // Decode substitutes this on bubbles; fetch itself never emits it.
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return pc & ~PC_W'(3);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through head, clear, and occupancy count.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the slot a same-cycle push lands in, so push is legal when full.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_queue_stage.sv
// Decoupled fetch: sequential PC generation, credit-limited requests to an in-order
// variable-latency imem, a response FIFO toward decode, and redirect flush with stale-drop.
module fetch_queue_stage import rv_fetch_pkg::*; #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [INSTR_W-1:0] if_instruction
);

   localparam int            CW  = $clog2(DEPTH+1);
   localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
   logic [PC_W-1:0]   target_full;
   logic [CW-1:0]     outstanding_q, outstanding_d, drop_q, drop_d, count;
   logic              req_fire, drop_active, push, pop, full, empty;
   fetch_entry_t      wentry, head;

   assign target_full = align_pc(PC_W'(redirect_pc));
   assign target      = target_full[ADDR_W-1:0];

   // Entries plus in-flight requests never exceed DEPTH, so responses always fit.
   assign imem_req_valid = (({1'b0, count} + {1'b0, outstanding_q}) < CAP) && !reset;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign drop_active = (drop_q != '0);
   assign push        = imem_resp_valid && !drop_active && !redirect_valid;
   assign pop         = !empty && if_ready && !redirect_valid;

   always_comb begin
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
      drop_d        = drop_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      // Every request still in flight after a redirect belongs to the old path.
      if (redirect_valid) begin
         drop_d     = outstanding_d;
         fetch_pc_d = target;
         resp_pc_d  = target;
      end else begin
         if (imem_resp_valid && drop_active) drop_d = drop_q - CW'(1);
         if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
         if (push)     resp_pc_d  = resp_pc_q + ADDR_W'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   assign wentry.pc    = PC_W'(resp_pc_q);
   assign wentry.instr = imem_resp_data;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wentry),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign if_valid       = !empty;
   assign if_pc          = empty ? '0 : head.pc[ADDR_W-1:0];
   assign if_instruction = empty ? '0 : head.instr;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> !full);
   a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> (outstanding_q != '0));
   a_credit: assert property (@(posedge clk) disable iff (reset)
      ({1'b0, count} + {1'b0, outstanding_q}) <= CAP);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage: in-order imem model plus a scoreboard of the
// instruction stream decode should see (sequential PCs restarting at each redirect/reset).
module tb_fetch_queue_stage;

   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [63:0] if_pc;
   logic [31:0] if_instruction;

   fetch_queue_stage #(.ADDR_W(64), .RESET_PC(RESET_PC), .DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instruction  (if_instruction)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] addr; int due; } pend_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

   pend_t       pend[$];
   exp_t        expq[$];
   logic [63:0] mfpc = RESET_PC;
   int          cyc = 0;
   int          n_tests = 0, n_fail = 0, n_pops = 0;

   int          pct_rr = 100, pct_ifr = 100, pct_redir = 0;
   int          lat_min = 1, lat_max = 1;
   logic        rst_k = 1'b1, redir_k = 1'b0;
   logic [63:0] redir_tgt = '0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock cycle: drive inputs at negedge, then account for handshakes at the next posedge.
   task automatic step();
      @(negedge clk);
      reset           = rst_k;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (rst_k) pend.delete();
      else if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end
      imem_req_ready = ($urandom_range(99) < pct_rr);
      if_ready       = ($urandom_range(99) < pct_ifr);
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (!rst_k && (redir_k || ($urandom_range(99) < pct_redir))) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_k ? redir_tgt : {$urandom(), $urandom()};
      end
      redir_k = 1'b0;
      #1;
      if (rst_k) begin
         expq.delete();
         mfpc = RESET_PC;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, mfpc);
            pend.push_back('{addr: imem_req_addr,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
            if (!redirect_valid) expq.push_back('{pc: mfpc, instr: mem_word(mfpc)});
            mfpc = mfpc + 64'd4;
         end
         if (redirect_valid) begin
            expq.delete();
            mfpc = redirect_pc & ~64'd3;
         end
      end
      cyc++;
   endtask

   // Monitor: every decode handshake must match the head of the expected stream.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && !redirect_valid && if_valid && if_ready) begin
            n_pops++;
            if (expq.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               chk("if_pc", if_pc, expq[0].pc);
               chk("if_instruction", {32'h0, if_instruction}, {32'h0, expq[0].instr});
               void'(expq.pop_front());
            end
         end else if (!reset && !if_valid) begin
            chk("empty_zero", {if_instruction, if_pc[31:0]}, 64'h0);
         end
      end
   end

   task automatic do_reset(input int n);
      rst_k = 1'b1;
      repeat (n) step();
      rst_k = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int limit);
      for (int i = 0; i < limit && !if_valid; i++) step();
      chk(name, if_valid, 1'b1);
   endtask

   initial begin
      // Reset state and 1-cycle memory streaming
      do_reset(2);
      rst_k = 1'b1;
      step();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", {32'h0, if_instruction}, 0);
      rst_k = 1'b0;
      step();
      chk("t1_req_valid", imem_req_valid, 1);
      chk("t1_req_addr0", imem_req_addr, 64'h0);
      step();
      chk("t1_not_yet", if_valid, 0);
      step();
      chk("t1_first_valid", if_valid, 1);
      chk("t1_first_pc", if_pc, 64'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_stream", if_valid, 1);
      end

      // Decode stall fills the FIFO and throttles requests
      do_reset(2);
      pct_ifr = 0;
      repeat (10) step();
      chk("t2_req_throttled", imem_req_valid, 0);
      chk("t2_head_valid", if_valid, 1);
      chk("t2_head_pc", if_pc, 64'h0);
      pct_ifr = 100;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_drain_order", if_pc, 64'(4 * i));
      end

      // 3-cycle memory, redirect drops stale responses
      do_reset(2);
      lat_min = 3; lat_max = 3;
      repeat (8) step();
      redir_k = 1'b1; redir_tgt = 64'h100;
      step();
      step();
      chk("t3_bubble", if_valid, 0);
      wait_valid("t3_timeout", 20);
      chk("t3_pc", if_pc, 64'h100);
      chk("t3_instr", {32'h0, if_instruction}, {32'h0, mem_word(64'h100)});

      // Redirect coinciding with a response and a decode pop
      lat_min = 1; lat_max = 1;
      repeat (6) step();
      redir_k = 1'b1; redir_tgt = 64'h200;
      step();
      chk("t4_pop_in_redirect", if_valid, 1);
      step();
      chk("t4_flushed", if_valid, 0);
      wait_valid("t4_timeout", 20);
      chk("t4_pc", if_pc, 64'h200);

      // Unaligned redirect target with memory back-pressure
      pct_rr = 0;
      redir_k = 1'b1; redir_tgt = 64'h103;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_req_valid", imem_req_valid, 1);
         chk("t5_addr_stable", imem_req_addr, 64'h100);
      end
      pct_rr = 100;
      wait_valid("t5_timeout", 20);
      chk("t5_pc", if_pc, 64'h100);

      // PC wraps past the top of the address space
      redir_k = 1'b1; redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      step();
      chk("t6_req_valid", imem_req_valid, 1);
      chk("t6_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk("t6_addr_wrap", imem_req_addr, 64'h0);
      wait_valid("t6_timeout", 20);
      chk("t6_pc_top", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Reset with requests in flight
      lat_min = 3; lat_max = 3;
      repeat (5) step();
      rst_k = 1'b1;
      step();
      chk("t7_req_in_reset", imem_req_valid, 0);
      step();
      chk("t7_if_valid", if_valid, 0);
      chk("t7_if_pc", if_pc, 0);
      chk("t7_if_instr", {32'h0, if_instruction}, 0);
      rst_k = 1'b0;
      step();
      chk("t7_restart_valid", imem_req_valid, 1);
      chk("t7_restart_addr", imem_req_addr, RESET_PC);

      // Randomized traffic
      lat_min = 1; lat_max = 4;
      pct_rr = 70; pct_ifr = 60; pct_redir = 3;
      for (int i = 0; i < 3000; i++) begin
         rst_k = ((i % 1000) >= 998);
         step();
      end
      rst_k = 1'b0;
      pct_redir = 0;
      repeat (10) step();
      #5;
      chk("liveness", 64'(n_pops >= 300), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Decoupled instruction-fetch front end for the 5-stage RV64 pipeline. Replaces the single-cycle fetch that feeds the IF/ID register.
- Generates sequential PCs and issues requests to a variable-latency, in-order instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- On a taken branch from the MEM stage it flushes the FIFO and discards in-flight stale responses.

Parameters:
- RESET_PC, 64'h0, first fetch address after reset
- DEPTH, 4, FIFO entries (power of two, ≥2); also the cap on entries plus outstanding requests
- ADDR_W, 64, PC width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  taken-branch redirect (BranchTaken)
- redirect_pc  in  ADDR_W  branch target; bits [1:0] are ignored and treated as 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address
- imem_resp_valid  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_resp_data  in  32  instruction word
- if_valid  out  1  head entry valid toward decode
- if_ready  in  1  decode accepts head (low = stall)
- if_pc  out  ADDR_W  PC of head entry
- if_instruction  out  32  instruction of head entry

Behaviour:
- Reset (sync, active-high):
  - fetch_pc ← RESET_PC
  - FIFO emptied; outstanding ← 0; drop_cnt ← 0
  - Outputs: if_valid 0, if_pc 0, if_instruction 0, imem_req_valid 0
  - Reset asserted mid-operation discards everything. Responses arriving after reset deasserts for pre-reset requests are the memory's responsibility; the bench holds memory idle during reset.
- Request issue:
  - imem_req_valid = (count + outstanding < DEPTH) && !reset
  - imem_req_addr = fetch_pc
  - On a valid&ready handshake: fetch_pc ← fetch_pc + 4 (wraps modulo 2^ADDR_W) and outstanding increments.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {pc, data} is pushed; pc comes from an internal resp_pc counter that advances by 4 per pushed response.
  - The credit rule guarantees the FIFO never overflows. A response arriving with a full FIFO is an assertion failure.
- Decode handshake:
  - if_valid = FIFO non-empty; if_pc and if_instruction show the head entry.
  - Pop on if_valid && if_ready.
  - When empty: if_pc 0, if_instruction 32'h0.
  - Push and pop in the same cycle are both allowed at any occupancy, including full.
- Redirect (highest priority, evaluated the same cycle):
  - FIFO cleared. Any push or pop that cycle is void; a decode handshake that cycle counts as consumed.
  - drop_cnt ← outstanding + (request accepted this cycle ? 1 : 0) − (resp_valid this cycle ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}. A request accepted in the redirect cycle used the old PC and is counted as stale.
  - resp_pc ← same target.
  - The first new request may issue the cycle after the redirect.
  - if_valid is 0 the cycle after the redirect.
  - Back-to-back redirects: the latest wins; drop_cnt accumulates correctly.
- Latency: redirect or reset → first request next cycle → with 1-cycle memory, if_valid two cycles after the request is accepted (response cycle, then registered FIFO write).
- Counter widths: outstanding and drop_cnt are $clog2(DEPTH+1) bits; count is $clog2(DEPTH+1) bits.
- Invariant (asserted): count + outstanding ≤ DEPTH.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - INSTR_W = 32, PC_STEP = 4
  - fetch_entry_t {pc, instr}
  - NOP_INSTR = 32'h00000013, for use by decode on bubbles
- One sub-module, sync_fifo: parameterised depth and width, push/pop/clear, count, full/empty, first-word fall-through head.

Test Plan:
- Reset, 1-cycle memory, if_ready=1 → requests at 0x0, 0x4, 0x8…; if_pc 0x0 appears 2 cycles after the first acceptance, then one instruction per cycle.
- if_ready=0 for 10 cycles → FIFO fills to 4 entries; imem_req_valid drops to 0 with count+outstanding=4; releasing if_ready drains in order 0x0..0xC with no loss.
- 3-cycle memory latency with 3 outstanding, redirect_pc=0x100 → the 3 stale responses are dropped; the next if_pc is 0x100 with the instruction from address 0x100.
- Redirect in the same cycle as a response and a decode pop → FIFO empty next cycle; the simultaneous response is dropped; no underflow.
- redirect_pc=0x103 → fetch restarts at 0x100; imem_req_ready held 0 for 5 cycles → imem_req_addr stays stable at 0x100.
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC → next request address is 0x0 (wrap). Reset asserted with 2 outstanding → all outputs return to reset values the next cycle.
